// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequential words from memory ahead of decode and
// flushes on redirect. Defining FETCH_QUEUE_PERF_EN adds the fetch_cnt/flush_cnt counters.
module fetch_queue #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 16,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [DATA_W-1:0]  NOP      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] target,
  input  logic              target_en,
  input  logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] inst_if,
  output logic [ADDR_W-1:0] npc_if,
  output logic              valid_if,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]       fetch_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic [1:0]        dbg_state
);

  // Memory handshake: mem_req stays high with mem_addr stable from issue until the
  // cycle mem_ack is seen; each mem_ack completes exactly one request.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [ADDR_W-1:0] r_q_npc  [DEPTH];

  logic              w_full;
  logic              w_valid;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_req;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_full   = (r_count == DEPTH_C);
  assign w_valid  = (r_count != '0);
  assign w_pc_inc = r_pc + ADDR_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!target_en && !w_full) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack)        w_next_state = S_IDLE;
        else if (target_en) w_next_state = S_DROP;
      end
      S_DROP: begin
        if (mem_ack) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_req   = 1'b0;
    w_issue = 1'b0;
    w_push  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_issue = !target_en && !w_full;
      end
      S_WAIT: begin
        w_req  = 1'b1;
        w_push = mem_ack && !target_en;
      end
      S_DROP: begin
        w_req = 1'b1;
      end
      default: begin
        w_req = 1'b0;
      end
    endcase
  end

  assign w_pop = w_valid && !stall && !target_en;

  // A redirect wins over sequential advance in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_addr <= RESET_PC;
    end else begin
      if (target_en)   r_pc <= target;
      else if (w_push) r_pc <= w_pc_inc;
      if (w_issue)     r_addr <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (target_en) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: it is only visible through the count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= mem_rdata;
      r_q_npc[r_wr_ptr]  <= w_pc_inc;
    end
  end

  assign mem_req   = w_req;
  assign mem_addr  = r_addr;
  assign valid_if  = w_valid;
  assign inst_if   = w_valid ? r_q_data[r_rd_ptr] : NOP;
  assign npc_if    = w_valid ? r_q_npc[r_rd_ptr]  : '0;
  assign dbg_state = r_state;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_push && (r_fetch_cnt != '1))    r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (target_en && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
